// File: rtl/mul_div_seq_if.sv
// Request/result bundle between the EX-stage control and the multiply/divide sequencer.
// master = CPU side issuing operations, slave = sequencer.
interface mul_div_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    modport master (
        output start, op, opa, opb,
        input  busy, done, res_hi, res_lo
    );

    modport slave (
        input  start, op, opa, opb,
        output busy, done, res_hi, res_lo
    );
endinterface

// File: rtl/mul_div_seq.sv
// Multi-cycle unsigned shift-add multiplier / restoring divider that borrows the
// datapath's external adder for one add or subtract per iteration.
module mul_div_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    mul_div_seq_if.slave     bus,
    output logic [WIDTH-1:0] add_a_o,
    output logic [WIDTH-1:0] add_b_o,
    output logic             add_cin_o,
    input  logic [WIDTH-1:0] add_sum_i,
    input  logic             add_cout_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] trial;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            count_q  <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            count_q  <= count_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        m_d       = m_q;
        count_d   = count_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        add_a_o   = '0;
        add_b_o   = '0;
        add_cin_o = 1'b0;
        // Partial remainder shifted left with the next dividend bit brought in
        trial     = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    m_d     = bus.opb;
                    count_d = '0;
                    hi_d    = '0;
                    lo_d    = bus.opa;
                    if (!bus.op) begin
                        state_d = S_MUL;
                    end else if (bus.opb != '0) begin
                        state_d = S_DIV;
                    end else begin
                        state_d  = S_DONE;
                        res_hi_d = bus.opa;
                        res_lo_d = '1;
                    end
                end
            end
            S_MUL: begin
                add_a_o = hi_q;
                add_b_o = lo_q[0] ? m_q : '0;
                {hi_d, lo_d} = {add_cout_i, add_sum_i, lo_q[WIDTH-1:1]};
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_CNT) begin
                    state_d  = S_DONE;
                    res_hi_d = hi_d;
                    res_lo_d = lo_d;
                end
            end
            S_DIV: begin
                add_a_o   = trial;
                add_b_o   = ~m_q;
                add_cin_o = 1'b1;
                // Carry-out set means trial >= M: keep the difference, quotient bit 1
                if (add_cout_i) begin
                    hi_d = add_sum_i;
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = trial;
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_CNT) begin
                    state_d  = S_DONE;
                    res_hi_d = hi_d;
                    res_lo_d = lo_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.res_hi = res_hi_q;
    assign bus.res_lo = res_lo_q;

endmodule
